weight_loader: RTL and testbench
================================

WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of one weight word.
REQ-002 Parameter NUM_WORDS, default 150, words loaded per request; SHALL be >= 1.
REQ-003 Parameter ADDR_WIDTH, default 8; SHALL satisfy 2**ADDR_WIDTH >= NUM_WORDS.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  1  level load request from the network controller, held high while the controller sits in the load state.
REQ-007 src_valid  input  1  source word available.
REQ-008 src_data  input  DATA_WIDTH  source weight word.
REQ-009 src_ready  output  1  loader accepts a word this cycle.
REQ-010 wr_en  output  1  buffer write strobe.
REQ-011 wr_addr  output  ADDR_WIDTH  buffer write address.
REQ-012 wr_data  output  DATA_WIDTH  buffer write data.
REQ-013 done  output  1  one-cycle completion pulse back to the controller.
REQ-014 busy  output  1  high while in LOAD.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, DONE, RELEASE, held in a register clocked by clk.
REQ-016 IDLE: src_ready=0; if req=1, go to LOAD next cycle and clear the word counter.
REQ-017 LOAD: src_ready=1, busy=1; a handshake is any cycle with src_valid=1 and src_ready=1.
REQ-018 Each handshake SHALL register wr_en=1, wr_addr=counter, wr_data=src_data on the same edge; the write is visible the cycle after the handshake; wr_en=0 in all other cycles.
REQ-019 The counter SHALL increment by 1 per handshake, width ceil(log2(NUM_WORDS)) bits minimum, and SHALL never exceed NUM_WORDS-1.
REQ-020 A handshake with counter=NUM_WORDS-1 SHALL move the FSM to DONE; addresses written are exactly 0..NUM_WORDS-1 in order.
REQ-021 src_valid=0 cycles in LOAD SHALL stall with no write and no counter change; there is no timeout.
REQ-022 DONE: done=1 for exactly one cycle, src_ready=0; next state RELEASE unconditionally.
REQ-023 The last word's wr_en and done SHALL be high in the same cycle; latency from the last handshake to done is 1 cycle.
REQ-024 RELEASE: src_ready=0, done=0; stay while req=1; go to IDLE when req=0. A held req SHALL NOT start a second load.
REQ-025 req=0 during LOAD (abort) SHALL return to IDLE next cycle, with no done and the counter cleared; a handshake in the abort cycle SHALL still be written.
REQ-026 src_ready, busy and done SHALL be decoded from the state register only (Moore); they SHALL NOT depend combinationally on any input.
REQ-027 With NUM_WORDS=1, the first handshake SHALL go directly to DONE.
REQ-028 An illegal state encoding SHALL return to IDLE next cycle.

Reset
REQ-029 reset_n=0 SHALL immediately force state=IDLE, counter=0, src_ready=0, wr_en=0, wr_addr=0, wr_data=0, done=0, busy=0.
REQ-030 Reset during LOAD SHALL discard progress; after release, the next req restarts at address 0.
REQ-031 The first rising edge after reset_n deasserts SHALL behave as IDLE.

Verification
REQ-032 NUM_WORDS=4, req held high, src_valid always 1, data 0xA0..0xA3 -> writes at addr 0..3, done high 1 cycle coincident with the addr-3 write, 4 LOAD cycles.
REQ-033 NUM_WORDS=4, src_valid toggling 1/0 -> exactly 4 writes, addresses contiguous, done one cycle after the 4th handshake.
REQ-034 req kept high 10 cycles after done -> FSM stays in RELEASE with src_ready=0 and no writes; req low then high -> fresh load from addr 0.
REQ-035 req dropped after 2 of 4 handshakes -> no done, IDLE next cycle; next req writes addr 0..3 again.
REQ-036 reset_n pulsed low mid-LOAD (asynchronous to clk) -> all outputs 0 immediately; subsequent load completes normally from addr 0.
REQ-037 NUM_WORDS=1, single handshake with data 0x5 -> wr_addr=0, wr_data=0x5, done in the same cycle as the write.

Source files
------------

// File: rtl/weight_loader_if.sv
// Weight-loader bus: the controller/source side and the buffer write port.
// The controller drives the request and the source word. The loader drives the handshake, the write port and the status.
interface weight_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  req;
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  done;
  logic                  busy;

  modport master (
    output req, src_valid, src_data,
    input  src_ready, wr_en, wr_addr, wr_data, done, busy
  );

  modport slave (
    input  req, src_valid, src_data,
    output src_ready, wr_en, wr_addr, wr_data, done, busy
  );
endinterface

// File: rtl/weight_loader.sv
// Streams NUM_WORDS source words into a weight buffer at addresses 0..NUM_WORDS-1.
// It pulses done once per completed load and waits for req to drop before it re-arms.
module weight_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WORDS  = 150,
  parameter int ADDR_WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  weight_loader_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_DONE    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  handshake;

  // Moore outputs: these depend only on the state register.
  assign bus.src_ready = (state_q == ST_LOAD);
  assign bus.busy      = (state_q == ST_LOAD);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;

  assign handshake = (state_q == ST_LOAD) && bus.src_valid;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          state_d = ST_LOAD;
          count_d = '0;
        end
      end
      ST_LOAD: begin
        // An abort takes priority over completion. The write stage still captures the abort-cycle word.
        if (!bus.req) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (handshake) begin
          if (count_q == LAST_ADDR) begin
            state_d = ST_DONE;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!bus.req) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignment, so all flops update together on the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // The write port is registered, so each word appears one cycle after its handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= handshake;
      if (handshake) begin
        wr_addr_q <= count_q;
        wr_data_q <= bus.src_data;
      end
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: full loads, stalls, release hold, abort, mid-load reset.
// It also covers the single-word configuration.
module tb_weight_loader;

  localparam int DW = 16;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  weight_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus4 ();
  weight_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  weight_loader #(.DATA_WIDTH(DW), .NUM_WORDS(4), .ADDR_WIDTH(AW)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4)
  );
  weight_loader #(.DATA_WIDTH(DW), .NUM_WORDS(1), .ADDR_WIDTH(AW)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Monitor: logs what the 4-word loader does, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_wr, n_done, n_busy, n_ready, n_hs, last_hs_cyc, done_cyc, wr_at_done;
  logic [AW-1:0] wlog_addr [32];
  logic [DW-1:0] wlog_data [32];
  int n_wr1, n_done1, wr1_with_done;
  logic [AW-1:0] w1_addr;
  logic [DW-1:0] w1_data;
  logic [DW-1:0] data_base;

  always @(negedge clk) begin
    if (bus4.wr_en) begin
      if (n_wr < 32) begin
        wlog_addr[n_wr] = bus4.wr_addr;
        wlog_data[n_wr] = bus4.wr_data;
      end
      n_wr++;
      if (bus4.done) wr_at_done = n_wr;
    end
    if (bus4.done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (bus4.busy) n_busy++;
    if (bus4.src_ready) n_ready++;
    if (bus4.src_valid && bus4.src_ready) begin
      n_hs++;
      last_hs_cyc = cyc;
    end
    if (bus1.wr_en) begin
      n_wr1++;
      w1_addr       = bus1.wr_addr;
      w1_data       = bus1.wr_data;
      wr1_with_done = int'(bus1.done);
    end
    if (bus1.done) n_done1++;
  end

  task automatic clear_log(input logic [DW-1:0] base);
    n_wr = 0; n_done = 0; n_busy = 0; n_ready = 0; n_hs = 0;
    last_hs_cyc = 0; done_cyc = 0; wr_at_done = 0;
    data_base     = base;
    bus4.src_data = base;
  endtask

  // Inputs change 2 ns after each rising edge. The next word is always base + handshakes so far.
  task automatic step();
    @(posedge clk);
    #2;
    bus4.src_data = data_base + DW'(n_hs);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) step();
  endtask

  task automatic check_seq(input string tag, input logic [DW-1:0] base);
    check({tag, "_nwr"}, n_wr, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_addr%0d", tag, i), wlog_addr[i], i);
      check($sformatf("%s_data%0d", tag, i), wlog_data[i], base + DW'(i));
    end
    check({tag, "_ndone"}, n_done, 1);
  endtask

  task automatic go_idle();
    bus4.req = 1'b0; bus4.src_valid = 1'b0;
    step(); step();
  endtask

  initial begin
    bus4.req = 1'b0; bus4.src_valid = 1'b0; bus4.src_data = '0;
    bus1.req = 1'b0; bus1.src_valid = 1'b0; bus1.src_data = '0;
    n_wr1 = 0; n_done1 = 0; wr1_with_done = 0; w1_addr = '0; w1_data = '0;
    clear_log(16'h00A0);
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #20;
    check("rst_src_ready", bus4.src_ready, 0);
    check("rst_wr_en",     bus4.wr_en,     0);
    check("rst_wr_addr",   bus4.wr_addr,   0);
    check("rst_wr_data",   bus4.wr_data,   0);
    check("rst_done_busy", {bus4.done, bus4.busy}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Full load with source always valid and req held.
    step();
    clear_log(16'h00A0);
    bus4.req = 1'b1; bus4.src_valid = 1'b1;
    wait_done(20);
    check_seq("full", 16'h00A0);
    check("full_done_with_last_wr", wr_at_done, 4);
    check("full_load_cycles", n_busy, 4);
    check("full_done_latency", done_cyc - last_hs_cyc, 1);

    // req stays high after done: the loader parks in RELEASE.
    repeat (10) step();
    check("rel_nwr",       n_wr, 4);
    check("rel_ready_cyc", n_ready, 4);
    check("rel_src_ready", bus4.src_ready, 0);
    check("rel_ndone",     n_done, 1);
    go_idle();
    clear_log(16'h00A0);
    bus4.req = 1'b1; bus4.src_valid = 1'b1;
    wait_done(20);
    check_seq("reload", 16'h00A0);

    // Source valid alternates, starting high in the IDLE cycle.
    go_idle();
    clear_log(16'h00B0);
    bus4.req = 1'b1; bus4.src_valid = 1'b1;
    for (int i = 0; i < 40 && n_done == 0; i++) begin
      step();
      bus4.src_valid = ~bus4.src_valid;
    end
    check_seq("stall", 16'h00B0);
    check("stall_load_cycles", n_busy, 8);
    check("stall_done_latency", done_cyc - last_hs_cyc, 1);

    // req drops in the second LOAD cycle while valid is still high. That word is still written.
    go_idle();
    clear_log(16'h00C0);
    bus4.req = 1'b1; bus4.src_valid = 1'b1;
    step();
    step();
    bus4.req = 1'b0;
    step();
    bus4.src_valid = 1'b0;
    check("abort_busy",    bus4.busy, 0);
    check("abort_ready",   bus4.src_ready, 0);
    check("abort_wr_en",   bus4.wr_en, 1);
    check("abort_wr_addr", bus4.wr_addr, 1);
    step(); step();
    check("abort_nwr",   n_wr, 2);
    check("abort_ndone", n_done, 0);
    clear_log(16'h00C0);
    bus4.req = 1'b1; bus4.src_valid = 1'b1;
    wait_done(20);
    check_seq("after_abort", 16'h00C0);

    // Asynchronous reset mid-load.
    go_idle();
    clear_log(16'h00D0);
    bus4.req = 1'b1; bus4.src_valid = 1'b1;
    step(); step();
    #1 reset_n = 1'b0;
    #1;
    check("mrst_ready_busy", {bus4.src_ready, bus4.busy, bus4.done}, 0);
    check("mrst_wr_en",      bus4.wr_en,   0);
    check("mrst_wr_addr",    bus4.wr_addr, 0);
    check("mrst_wr_data",    bus4.wr_data, 0);
    clear_log(16'h0010);
    #2 reset_n = 1'b1;
    wait_done(20);
    check_seq("post_rst", 16'h0010);

    // Single-word configuration. A held req must not start a second load.
    go_idle();
    bus1.req = 1'b1; bus1.src_valid = 1'b1; bus1.src_data = 16'h0005;
    for (int i = 0; i < 10 && n_wr1 == 0; i++) step();
    check("one_nwr",  n_wr1, 1);
    check("one_addr", w1_addr, 0);
    check("one_data", w1_data, 16'h0005);
    check("one_done_with_wr", wr1_with_done, 1);
    repeat (5) step();
    check("one_held_nwr",   n_wr1, 1);
    check("one_held_ndone", n_done1, 1);
    bus1.req = 1'b0; bus1.src_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
